// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Byte FIFO feeding an 8N1 UART transmitter (start bit, 8 data bits
//   LSB first, one stop bit). Bytes are sent in the order they were written.
//   When a frame ends and another byte is waiting, the next start bit follows
//   the stop bit with no idle time on the line.
//
// Parameters
//   CLKS_PER_BIT  clocks per serial bit (default 1250 = 12 MHz / 9600 baud)
//   FIFO_DEPTH    FIFO entries; must be a power of two, at least 2
//
// Ports
//   clk         system clock, rising edge
//   nrst        synchronous reset, active low
//   wr_data     byte to queue
//   wr_valid    wr_data is valid this cycle
//   wr_ready    FIFO not full (combinational from fifo_count)
//   tx          serial output, idles high, registered
//   busy        transmitter is not idle
//   fifo_count  number of bytes waiting in the FIFO
//   overflow    one-cycle pulse after a write was dropped because the FIFO was full
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 1250,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  // The period counter needs at least one bit even when CLKS_PER_BIT is 1.
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // FIFO storage. Not reset: the pointers and count alone define what is valid.
  logic [7:0]    mem [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW:0]   count_reg, count_next;
  logic          overflow_reg, overflow_next;

  state_t        state_reg, state_next;
  logic [CW-1:0] period_reg, period_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    shift_reg, shift_next;
  logic          tx_reg, tx_next;

  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic          period_done;

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  // Readiness is based only on the registered count, so a pop in the same
  // cycle never lets a full FIFO accept a byte.
  assign wr_ready   = (count_reg < (AW + 1)'(FIFO_DEPTH));
  assign push       = wr_valid && wr_ready;
  assign fifo_empty = (count_reg == '0);

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    overflow_next = wr_valid && !wr_ready;

    if (push) begin
      wr_ptr_next = wr_ptr_reg + AW'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + AW'(1);
    end

    // Simultaneous push and pop leaves the count unchanged.
    case ({push, pop})
      2'b10:   count_next = count_reg + (AW + 1)'(1);
      2'b01:   count_next = count_reg - (AW + 1)'(1);
      default: count_next = count_reg;
    endcase
  end

  // Writes during reset are discarded along with everything else.
  always_ff @(posedge clk) begin
    if (nrst && push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Transmitter FSM
  // ---------------------------------------------------------------------------
  assign period_done = (period_reg == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_next  = state_reg;
    period_next = period_reg + CW'(1);
    bit_next    = bit_reg;
    shift_next  = shift_reg;
    tx_next     = tx_reg;
    pop         = 1'b0;

    case (state_reg)
      IDLE: begin
        period_next = '0;
        tx_next     = 1'b1;
        if (!fifo_empty) begin
          // Head byte is captured straight into the shift register, which
          // doubles as the registered read port of the storage array.
          pop        = 1'b1;
          shift_next = mem[rd_ptr_reg];
          state_next = START;
          tx_next    = 1'b0;
        end
      end

      START: begin
        if (period_done) begin
          period_next = '0;
          bit_next    = 3'd0;
          state_next  = DATA;
          tx_next     = shift_reg[0];
        end
      end

      DATA: begin
        if (period_done) begin
          period_next = '0;
          if (bit_reg == 3'd7) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            // tx always follows bit 0 of the shift register; after the
            // shift that is the current bit 1.
            shift_next = {1'b0, shift_reg[7:1]};
            tx_next    = shift_reg[1];
            bit_next   = bit_reg + 3'd1;
          end
        end
      end

      STOP: begin
        if (period_done) begin
          period_next = '0;
          if (!fifo_empty) begin
            // Chain straight into the next frame without an idle bit.
            pop        = 1'b1;
            shift_next = mem[rd_ptr_reg];
            state_next = START;
            tx_next    = 1'b0;
          end else begin
            state_next = IDLE;
            tx_next    = 1'b1;
          end
        end
      end

      default: begin
        state_next  = IDLE;
        period_next = '0;
        tx_next     = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_reg    <= IDLE;
      period_reg   <= '0;
      bit_reg      <= 3'd0;
      shift_reg    <= 8'h00;
      tx_reg       <= 1'b1;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      period_reg   <= period_next;
      bit_reg      <= bit_next;
      shift_reg    <= shift_next;
      tx_reg       <= tx_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  assign tx         = tx_reg;
  assign busy       = (state_reg != IDLE);
  assign fifo_count = count_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//   Randomised and directed bench for uart_tx_fifo with CLKS_PER_BIT=4 and
//   FIFO_DEPTH=16. A byte-queue model predicts every output each cycle, and
//   an independent serial decoder on tx recovers bytes and matches them
//   against the write order.
module tb_uart_tx_fifo;

  localparam int C = 4;
  localparam int D = 16;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic       tx;
  logic       busy;
  logic [4:0] fifo_count;
  logic       overflow;

  uart_tx_fifo #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] q[$];      // bytes waiting in the FIFO
  logic [7:0] sent[$];   // accepted bytes not yet seen on the line
  bit         m_active = 0;
  int         m_el = 0;  // cycles since the frame's start bit began
  logic [7:0] m_byte = 8'h00;
  bit         m_ovf = 0;

  // monitors, cleared by the stimulus at the start of a directed test
  int busy_cycles = 0;
  int peak_count = 0;
  int ovf_cycles = 0;

  // serial decoder
  bit         dec_active = 0;
  int         dec_t = 0;
  logic [7:0] dec_byte = 8'h00;

  function automatic logic model_tx();
    int k;
    if (!m_active) return 1'b1;
    k = m_el / C;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[k-1];
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    bit full, acc, done;
    logic [7:0] exp_b;
    int k;
    if (!nrst) begin
      q.delete();
      sent.delete();
      m_active = 0;
      m_el = 0;
      m_ovf = 0;
      dec_active = 0;
    end else begin
      full = (q.size() == D);
      acc = wr_valid && !full;
      m_ovf = wr_valid && full;
      done = m_active && (m_el == 10*C - 1);
      if ((!m_active || done) && q.size() > 0) begin
        m_byte = q.pop_front();
        m_active = 1;
        m_el = 0;
      end else if (done) begin
        m_active = 0;
      end else if (m_active) begin
        m_el++;
      end
      if (acc) begin
        q.push_back(wr_data);
        sent.push_back(wr_data);
      end
    end

    #1;
    chk("tx", int'(tx), int'(model_tx()));
    chk("busy", int'(busy), int'(m_active));
    chk("fifo_count", int'(fifo_count), q.size());
    chk("wr_ready", int'(wr_ready), int'(q.size() < D));
    chk("overflow", int'(overflow), int'(m_ovf));

    if (busy) busy_cycles++;
    if (int'(fifo_count) > peak_count) peak_count = int'(fifo_count);
    if (overflow) ovf_cycles++;

    // decoder: sample each bit at its middle
    if (nrst) begin
      if (!dec_active) begin
        if (tx == 1'b0) begin
          dec_active = 1;
          dec_t = 0;
        end
      end else begin
        dec_t++;
      end
      if (dec_active && (dec_t % C) == C/2) begin
        k = dec_t / C;
        if (k == 0) begin
          chk("start_bit", int'(tx), 0);
        end else if (k <= 8) begin
          dec_byte[k-1] = tx;
        end else begin
          chk("stop_bit", int'(tx), 1);
          if (sent.size() == 0) begin
            chk("decoded_unexpected", int'(dec_byte), -1);
          end else begin
            exp_b = sent.pop_front();
            chk("decoded_byte", int'(dec_byte), int'(exp_b));
          end
          dec_active = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v, input logic [7:0] d);
    @(negedge clk);
    wr_valid = v;
    wr_data = d;
  endtask

  task automatic wait_idle(input int max_cycles);
    bit ok;
    ok = 0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (!busy && fifo_count == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  task automatic clear_monitors();
    @(negedge clk);
    busy_cycles = 0;
    peak_count = 0;
    ovf_cycles = 0;
  endtask

  logic exp_seq [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    // reset
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tx", int'(tx), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_count", int'(fifo_count), 0);
    chk("reset_wr_ready", int'(wr_ready), 1);
    nrst = 1'b1;
    drive(0, 8'h00);

    // single byte 0x53: literal frame shape
    clear_monitors();
    drive(1, 8'h53);
    drive(0, 8'h00);
    for (int i = 0; i < 10*C; i++) begin
      @(negedge clk);
      chk("frame53_tx", int'(tx), int'(exp_seq[i/C]));
      chk("frame53_busy", int'(busy), 1);
    end
    @(negedge clk);
    chk("frame53_end_tx", int'(tx), 1);
    chk("frame53_end_busy", int'(busy), 0);
    chk("frame53_busy_len", busy_cycles, 10*C);

    // back-to-back four bytes
    clear_monitors();
    drive(1, 8'h53);
    drive(1, 8'h6E);
    drive(1, 8'h61);
    drive(1, 8'h70);
    drive(0, 8'h00);
    wait_idle(60*C);
    chk("b2b_busy_len", busy_cycles, 40*C);
    chk("b2b_peak_count", peak_count, 3);

    // fill to full, one dropped write
    clear_monitors();
    for (int i = 0; i < 18; i++) drive(1, 8'($urandom_range(0, 255)));
    drive(0, 8'h00);
    chk("full_overflow", int'(overflow), 1);
    chk("full_count", int'(fifo_count), 16);
    chk("full_wr_ready", int'(wr_ready), 0);
    chk("full_ovf_cycles", ovf_cycles, 1);
    wait_idle(20*10*C);

    // write coinciding with a STOP-expiry pop while one byte waits
    drive(1, 8'hC3);
    drive(1, 8'h3C);
    for (int i = 0; i < 10*C - 1; i++) drive(0, 8'h00);
    drive(1, 8'h99);
    drive(0, 8'h00);
    chk("pop_push_count", int'(fifo_count), 1);
    wait_idle(40*C);

    // reset mid-frame (data bit 3) with five bytes queued
    for (int i = 0; i < 6; i++) drive(1, 8'(8'h10 + i));
    for (int i = 0; i < 4*C - 3; i++) drive(0, 8'h00);
    @(negedge clk);
    nrst = 1'b0;
    wr_valid = 1'b1;
    wr_data = 8'hFF;
    @(negedge clk);
    chk("midreset_tx", int'(tx), 1);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_count", int'(fifo_count), 0);
    nrst = 1'b1;
    wr_valid = 1'b0;
    drive(1, 8'hA5);
    drive(0, 8'h00);
    wait_idle(20*C);

    // randomized traffic, many frames, pointer wrap and occasional overflow
    for (int i = 0; i < 1700; i++) drive(($urandom_range(0, 7) == 0), 8'($urandom_range(0, 255)));
    drive(0, 8'h00);
    wait_idle(20*10*C);
    repeat (2) @(negedge clk);
    chk("all_bytes_decoded", sent.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
